// File: rtl/paralelo_serial_tx_gen_pkg.sv
// Shared PHY definitions for the serial TX/RX path: comma constant, link state
// encoding and a constant-width helper.
package paralelo_serial_tx_gen_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/paralelo_serial_tx_gen_if.sv
// Word-level load handshake between the TX striping/FIFO logic and the serialiser.
interface paralelo_serial_tx_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial_tx_gen_contador_palabra.sv
// Bit-position counter for one serial word; flags the load edge and marks word
// starts. Shared with the serial-to-parallel receiver.
module contador_palabra
  import paralelo_serial_tx_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = clog2(WIDTH)
) (
  input  logic clk_32f,
  input  logic reset_L,
  output logic load_edge,
  output logic word_start
);

  logic [IW-1:0] r_index;
  logic          r_word_start;

  // Reset parks the counter on the last bit so the first edge loads a word.
  assign load_edge  = (r_index == IW'(WIDTH - 1));
  assign word_start = r_word_start;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_index      <= IW'(WIDTH - 1);
      r_word_start <= 1'b0;
    end else begin
      r_word_start <= load_edge;
      if (load_edge) begin
        r_index <= '0;
      end else begin
        r_index <= r_index + IW'(1);
      end
    end
  end

endmodule

// File: rtl/paralelo_serial_tx_gen.sv
// Parallel-to-serial transmitter: sync phase of comma words after reset, then
// valid/ready word loading with comma fill, gapless bit stream.
module paralelo_serial_tx_gen
  import paralelo_serial_tx_gen_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(K28_5),
  parameter bit               MSB_FIRST  = 1'b1,
  parameter int               SYNC_WORDS = 4
) (
  input  logic                    clk_32f,
  input  logic                    reset_L,
  paralelo_serial_tx_gen_if.slave tx_if,
  output logic                    data_out,
  output logic                    word_start,
  output logic                    active_out
);

  localparam int CW = clog2(SYNC_WORDS) + 1;

  tx_state_t        r_state, w_state_next;
  logic [CW-1:0]    r_sync_cnt, w_sync_cnt_next;
  logic             r_active, w_active_next;
  logic [WIDTH-1:0] r_shreg;
  logic             r_data;
  logic             w_load;
  logic             w_ready;
  logic [WIDTH-1:0] w_word;

  contador_palabra #(.WIDTH(WIDTH)) u_contador (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .load_edge (w_load),
    .word_start(word_start)
  );

  assign w_ready         = (r_state == ST_RUN) && w_load;
  assign tx_if.ready_out = w_ready;
  assign w_word          = (tx_if.valid_in && w_ready) ? tx_if.data_in : IDLE_WORD;
  assign data_out        = r_data;
  assign active_out      = r_active;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_SYNC;
      r_sync_cnt <= '0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sync_cnt <= w_sync_cnt_next;
      r_active   <= w_active_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sync_cnt_next = r_sync_cnt;
    w_active_next   = r_active;
    if (r_state == ST_SYNC && w_load) begin
      w_sync_cnt_next = r_sync_cnt + CW'(1);
      if (r_sync_cnt == CW'(SYNC_WORDS - 1)) begin
        w_state_next  = ST_RUN;
        w_active_next = 1'b1;
      end
    end
  end

  // The register holds the not-yet-sent bits, pre-shifted so the next bit is
  // always at the outgoing end.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_shreg <= IDLE_WORD;
      r_data  <= 1'b0;
    end else if (w_load) begin
      if (MSB_FIRST) begin
        r_data  <= w_word[WIDTH-1];
        r_shreg <= {w_word[WIDTH-2:0], 1'b0};
      end else begin
        r_data  <= w_word[0];
        r_shreg <= {1'b0, w_word[WIDTH-1:1]};
      end
    end else begin
      if (MSB_FIRST) begin
        r_data  <= r_shreg[WIDTH-1];
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_data  <= r_shreg[0];
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx_gen.sv
// Self-checking bench: three configurations (8-bit MSB-first, 8-bit LSB-first,
// 10-bit) driven by a word table and short hand-written sequences.
module tb_paralelo_serial_tx_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n, rstl_n, rst10_n;
  logic d8, ws8, act8;
  logic dl, wsl, actl;
  logic d10, ws10, act10;

  paralelo_serial_tx_gen_if #(.WIDTH(8))  if8 ();
  paralelo_serial_tx_gen_if #(.WIDTH(8))  ifl ();
  paralelo_serial_tx_gen_if #(.WIDTH(10)) if10 ();

  paralelo_serial_tx_gen #(
    .WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .SYNC_WORDS(2)
  ) u_dut8 (
    .clk_32f(clk), .reset_L(rst8_n), .tx_if(if8),
    .data_out(d8), .word_start(ws8), .active_out(act8)
  );

  paralelo_serial_tx_gen #(
    .WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0), .SYNC_WORDS(1)
  ) u_dut_lsb (
    .clk_32f(clk), .reset_L(rstl_n), .tx_if(ifl),
    .data_out(dl), .word_start(wsl), .active_out(actl)
  );

  paralelo_serial_tx_gen #(
    .WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b1), .SYNC_WORDS(1)
  ) u_dut10 (
    .clk_32f(clk), .reset_L(rst10_n), .tx_if(if10),
    .data_out(d10), .word_start(ws10), .active_out(act10)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] exp_w;
  } vec8_t;

  vec8_t tbl[9];
  int    n_vec = 0;
  int    n_err = 0;
  logic  q_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input int width, input bit msb);
    for (int i = 0; i < width; i++) begin
      q_exp.push_back(msb ? w[width-1-i] : w[i]);
    end
  endtask

  task automatic pop_chk(input string name, input logic act);
    logic e;
    if (q_exp.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %b expected nothing (scoreboard empty)", name, act);
    end else begin
      e = q_exp.pop_front();
      chk(name, {31'b0, act}, {31'b0, e});
    end
  endtask

  // One full word slot of the 8-bit MSB-first instance; r is the slot number
  // since reset release (SYNC_WORDS=2, so RUN begins at slot 1).
  task automatic run_slot8(input logic [7:0] w, input int r, input bit set_next,
                           input logic nv, input logic [7:0] nd);
    push_word({8'h00, w}, 8, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pop_chk("data8", d8);
      chk("wstart8", {31'b0, ws8}, {31'b0, c == 0});
      chk("active8", {31'b0, act8}, {31'b0, r >= 1});
      chk("ready8", {31'b0, if8.ready_out}, {31'b0, (c == 7) && (r >= 1)});
      if (c == 7 && set_next) begin
        if8.valid_in = nv;
        if8.data_in  = nd;
      end
    end
    $display("dut8 slot %0d: expected word %h", r, w);
  endtask

  initial begin
    rst8_n = 1'b0; rstl_n = 1'b0; rst10_n = 1'b0;
    if8.valid_in  = 1'b0; if8.data_in  = '0;
    ifl.valid_in  = 1'b0; ifl.data_in  = '0;
    if10.valid_in = 1'b0; if10.data_in = '0;

    // Valid during sync must be ignored; data_in ignored while valid is low.
    tbl[0] = '{1'b1, 8'hA5, 8'hBC};
    tbl[1] = '{1'b1, 8'hA5, 8'hBC};
    tbl[2] = '{1'b1, 8'hA5, 8'hA5};
    tbl[3] = '{1'b1, 8'h3C, 8'h3C};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF};
    tbl[5] = '{1'b0, 8'h00, 8'hBC};
    tbl[6] = '{1'b0, 8'h55, 8'hBC};
    tbl[7] = '{1'b1, 8'hFF, 8'hFF};
    tbl[8] = '{1'b0, 8'hFF, 8'hBC};

    repeat (2) @(negedge clk);
    chk("rst_data8",   {31'b0, d8},            32'd0);
    chk("rst_wstart8", {31'b0, ws8},           32'd0);
    chk("rst_active8", {31'b0, act8},          32'd0);
    chk("rst_ready8",  {31'b0, if8.ready_out}, 32'd0);

    if8.valid_in = tbl[0].v;
    if8.data_in  = tbl[0].d;
    rst8_n = 1'b1;
    for (int r = 0; r < 9; r++) begin
      if (r < 8) run_slot8(tbl[r].exp_w, r, 1'b1, tbl[r+1].v, tbl[r+1].d);
      else       run_slot8(tbl[r].exp_w, r, 1'b0, 1'b0, 8'h00);
    end

    // Reset in the middle of a data word.
    if8.valid_in = 1'b1;
    if8.data_in  = 8'hA5;
    push_word(16'h00A5, 8, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pop_chk("data8_pre_rst", d8);
    end
    if8.data_in = 8'h3C;
    #2 rst8_n = 1'b0;
    #1;
    chk("midrst_data8",   {31'b0, d8},            32'd0);
    chk("midrst_active8", {31'b0, act8},          32'd0);
    chk("midrst_ready8",  {31'b0, if8.ready_out}, 32'd0);
    q_exp.delete();
    @(negedge clk);
    chk("midrst_hold_data8", {31'b0, d8}, 32'd0);
    rst8_n = 1'b1;
    run_slot8(8'hBC, 0, 1'b0, 1'b0, 8'h00);
    run_slot8(8'hBC, 1, 1'b0, 1'b0, 8'h00);
    run_slot8(8'h3C, 2, 1'b1, 1'b0, 8'h00);

    // LSB-first instance: one sync word, then 8'h01.
    chk("rst_datal", {31'b0, dl}, 32'd0);
    ifl.valid_in = 1'b1;
    ifl.data_in  = 8'h01;
    @(negedge clk);
    rstl_n = 1'b1;
    push_word(16'h00BC, 8, 1'b0);
    push_word(16'h0001, 8, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      pop_chk("datal", dl);
      chk("readyl",  {31'b0, ifl.ready_out}, {31'b0, (k == 8) || (k == 16)});
      chk("wstartl", {31'b0, wsl},           {31'b0, (k % 8) == 1});
      chk("activel", {31'b0, actl},          32'd1);
      if (k == 9) ifl.valid_in = 1'b0;
    end
    $display("dutl: expected words BC then 01, LSB first");

    // 10-bit instance, idle only.
    chk("rst_data10", {31'b0, d10}, 32'd0);
    @(negedge clk);
    rst10_n = 1'b1;
    push_word(16'h017C, 10, 1'b1);
    push_word(16'h017C, 10, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      pop_chk("data10", d10);
      chk("ready10",  {31'b0, if10.ready_out}, {31'b0, (k % 10) == 0});
      chk("wstart10", {31'b0, ws10},           {31'b0, (k % 10) == 1});
      chk("active10", {31'b0, act10},          32'd1);
    end
    $display("dut10: expected words 17C, 17C");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
